// File: rtl/pe_array_stream_src_pkg.sv
// Shared definitions for the PE-array stream source and the arrays it feeds:
// sample width, playback state encoding and word/address width derivations.
package pe_array_stream_src_pkg;

    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_LANES      = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } src_state_t;

    // Each lane carries a complex (re, im) pair of samples.
    function automatic int word_width(input int data_width, input int lanes);
        return data_width * 2 * lanes;
    endfunction

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pe_array_stream_src_buf.sv
// pe_src_buf: simple dual-port word buffer (one write port, one sync read port)
// written so it maps onto block RAM; read data register resets to zero.
module pe_src_buf #(
    parameter int W     = 32,
    parameter int DEPTH = 512,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_en low holds the last word, which lets this register act as the stream output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pe_array_stream_src.sv
// Replays a host-preloaded word buffer into a PE array as framed valid/ready bursts.
// Optional build macro PE_SRC_CHECKSUM_EN adds an XOR checksum of transferred words.
module pe_array_stream_src
    import pe_array_stream_src_pkg::*;
#(
    parameter int DATA_WIDTH  = PE_DATA_WIDTH,
    parameter int LANES       = PE_LANES,
    parameter int DEPTH       = 512,
    parameter int LOAD_CYCLES = 2,
    parameter int GAP_CYCLES  = 4,
    localparam int W          = word_width(DATA_WIDTH, LANES),
    localparam int AW         = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic          wr_err,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   frame_len,
    input  logic [7:0]    num_frames,
    output logic          load,
    output logic          dout_v,
    input  logic          dout_ready,
    output logic [W-1:0]  dout,
    output logic          busy,
    output logic          done
`ifdef PE_SRC_CHECKSUM_EN
    ,
    output logic [W-1:0]  checksum
`endif
);

    localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    src_state_t    state_q, state_d;
    logic [AW:0]   len_q;
    logic [7:0]    nfr_q;
    logic [7:0]    frame_cnt;
    logic [3:0]    load_cnt;
    logic [7:0]    gap_cnt;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   iss_cnt;
    logic [AW:0]   xfer_cnt;

    logic adv, xfer, load_last, gap_last, frame_end, last_frame, start_acc, rd_en, addr_wrap;

    assign adv        = !dout_v || dout_ready;
    assign xfer       = dout_v && dout_ready;
    assign load_last  = (load_cnt == LOAD_LAST);
    assign gap_last   = (gap_cnt == GAP_LAST);
    assign frame_end  = (state_q == ST_STREAM) && xfer && (xfer_cnt == len_q - 1'b1);
    assign last_frame = (nfr_q != 8'd0) && (frame_cnt == nfr_q - 8'd1);
    assign start_acc  = (state_q == ST_IDLE) && start && !abort;
    assign addr_wrap  = ({1'b0, rd_addr} == len_q - 1'b1);

    // Word 0 is fetched in the last load cycle; afterwards fetch whenever the output stage frees up.
    assign rd_en = !abort &&
                   (((state_q == ST_LOAD) && load_last) ||
                    ((state_q == ST_STREAM) && adv && (iss_cnt != len_q)));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (frame_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                load = 1'b1;
                if (load_last) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (frame_end) begin
                    if (last_frame)           state_d = ST_DONE;
                    else if (GAP_CYCLES == 0) state_d = ST_LOAD;
                    else                      state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last) state_d = ST_LOAD;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_err    <= 1'b0;
            len_q     <= '0;
            nfr_q     <= '0;
            frame_cnt <= '0;
            load_cnt  <= '0;
            gap_cnt   <= '0;
            rd_addr   <= '0;
            iss_cnt   <= '0;
            xfer_cnt  <= '0;
            dout_v    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_err   <= wr_en && (state_q != ST_IDLE);
            load_cnt <= (state_q == ST_LOAD) ? load_cnt + 4'd1 : 4'd0;
            gap_cnt  <= (state_q == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;

            if (start_acc) begin
                len_q <= frame_len;
                nfr_q <= num_frames;
            end

            // Per-frame counters restart at every frame boundary and on leaving playback.
            if ((state_q == ST_IDLE) || abort || frame_end) begin
                iss_cnt  <= '0;
                xfer_cnt <= '0;
            end else begin
                if (rd_en) iss_cnt  <= iss_cnt + 1'b1;
                if (xfer)  xfer_cnt <= xfer_cnt + 1'b1;
            end

            if (state_q == ST_IDLE)  frame_cnt <= '0;
            else if (frame_end)      frame_cnt <= frame_cnt + 8'd1;

            if ((state_q == ST_IDLE) || abort) rd_addr <= '0;
            else if (rd_en)                    rd_addr <= addr_wrap ? '0 : rd_addr + 1'b1;

            if (abort)      dout_v <= 1'b0;
            else if (rd_en) dout_v <= 1'b1;
            else if (xfer)  dout_v <= 1'b0;
        end
    end

    pe_src_buf #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && (state_q == ST_IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (dout)
    );

`ifdef PE_SRC_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (start_acc) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum ^ dout;
        end
    end
`endif

endmodule

// File: tb/tb_pe_array_stream_src.sv
// Directed self-checking bench for pe_array_stream_src (default parameters).
// Define PE_SRC_CHECKSUM_EN for both RTL and bench to cover the checksum output.
module tb_pe_array_stream_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_err;
    logic        start;
    logic        abort;
    logic [9:0]  frame_len;
    logic [7:0]  num_frames;
    logic        load;
    logic        dout_v;
    logic        dout_ready;
    logic [31:0] dout;
    logic        busy;
    logic        done;
`ifdef PE_SRC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] got[$];
    int          gaps[$];
    int n_load, n_done, n_valid, n_stall, hold_bad;
    int first_valid, done_cyc, last_xfer_cyc, end_cyc;
    bit timed_out;

    always #5 clk = ~clk;

    pe_array_stream_src dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .start      (start),
        .abort      (abort),
        .frame_len  (frame_len),
        .num_frames (num_frames),
        .load       (load),
        .dout_v     (dout_v),
        .dout_ready (dout_ready),
        .dout       (dout),
        .busy       (busy),
        .done       (done)
`ifdef PE_SRC_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [8:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Starts a playback and observes it cycle by cycle until busy drops, the
    // abort point is reached, or the cycle budget runs out.
    task automatic play(input logic [9:0] len, input logic [7:0] nfr, input bit toggle,
                        input int abort_after, input int budget);
        bit          prev_stall;
        logic [31:0] prev_dout;
        int          gap_run;
        got.delete();
        gaps.delete();
        n_load = 0; n_done = 0; n_valid = 0; n_stall = 0; hold_bad = 0;
        first_valid = -1; done_cyc = -1; last_xfer_cyc = -1; end_cyc = -1;
        timed_out = 1'b0;
        prev_stall = 1'b0; prev_dout = '0; gap_run = 0;
        frame_len  = len;
        num_frames = nfr;
        dout_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int cyc = 1; ; cyc++) begin
            if (cyc > budget) begin
                timed_out = 1'b1;
                break;
            end
            if (!busy) begin
                end_cyc = cyc;
                break;
            end
            dout_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (prev_stall && (!dout_v || dout !== prev_dout)) hold_bad++;
            if (load) n_load++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (dout_v) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (dout_v && !dout_ready) n_stall++;
            if (!load && !dout_v && !done) begin
                gap_run++;
            end else if (gap_run > 0) begin
                gaps.push_back(gap_run);
                gap_run = 0;
            end
            prev_stall = dout_v && !dout_ready;
            prev_dout  = dout;
            if (dout_v && dout_ready) begin
                got.push_back(dout);
                last_xfer_cyc = cyc;
            end
            if (abort_after > 0 && got.size() == abort_after) begin
                abort = 1'b1;
                tick();
                abort   = 1'b0;
                end_cyc = cyc + 1;
                break;
            end
            tick();
        end
        dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; abort = 1'b0; frame_len = '0; num_frames = '0; dout_ready = 1'b1;
        tick();
        tick();
        checks++; if (load !== 1'b0)   begin errors++; $display("[TB] FAIL reset_load: got %b, want 0", load); end
        checks++; if (dout_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_v: got %b, want 0", dout_v); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("[TB] FAIL reset_done: got %b, want 0", done); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_err: got %b, want 0", wr_err); end
        checks++; if (dout !== 32'h0)  begin errors++; $display("[TB] FAIL reset_dout: got %h, want 0", dout); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 16; i++) write_word(9'(i), 32'h0001_0000 + 32'(i));
        play(10'd16, 8'd1, 1'b0, 0, 100);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL t1_timeout: playback did not finish"); end
        checks++; if (got.size() !== 16) begin errors++; $display("[TB] FAIL t1_count: got %0d, want 16", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'h0001_0000 + 32'(i)) begin
                errors++; $display("[TB] FAIL t1_word%0d: got %h, want %h", i, got[i], 32'h0001_0000 + 32'(i));
            end
        end
        checks++; if (n_load !== 2)       begin errors++; $display("[TB] FAIL t1_load_cycles: got %0d, want 2", n_load); end
        checks++; if (first_valid !== 3)  begin errors++; $display("[TB] FAIL t1_first_valid: got cycle %0d, want 3", first_valid); end
        checks++; if (last_xfer_cyc !== 18) begin errors++; $display("[TB] FAIL t1_last_word: got cycle %0d, want 18", last_xfer_cyc); end
        checks++; if (n_done !== 1)       begin errors++; $display("[TB] FAIL t1_done_count: got %0d, want 1", n_done); end
        checks++; if (done_cyc !== 19)    begin errors++; $display("[TB] FAIL t1_done_cycle: got %0d, want 19", done_cyc); end
        checks++; if (end_cyc !== 20)     begin errors++; $display("[TB] FAIL t1_busy_fall: got %0d, want 20", end_cyc); end
    endtask

    task automatic test_backpressure();
        play(10'd16, 8'd1, 1'b1, 0, 200);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL t2_timeout: playback did not finish"); end
        checks++; if (got.size() !== 16) begin errors++; $display("[TB] FAIL t2_count: got %0d, want 16", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'h0001_0000 + 32'(i)) begin
                errors++; $display("[TB] FAIL t2_word%0d: got %h, want %h", i, got[i], 32'h0001_0000 + 32'(i));
            end
        end
        checks++; if (hold_bad !== 0)  begin errors++; $display("[TB] FAIL t2_hold: %0d unstable stall cycles, want 0", hold_bad); end
        checks++; if (n_stall !== 15)  begin errors++; $display("[TB] FAIL t2_stalls: got %0d, want 15", n_stall); end
        checks++; if (done_cyc !== 34) begin errors++; $display("[TB] FAIL t2_done_cycle: got %0d, want 34", done_cyc); end
    endtask

    task automatic test_multi_frame();
        play(10'd5, 8'd3, 1'b0, 0, 200);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL t3_timeout: playback did not finish"); end
        checks++; if (got.size() !== 15) begin errors++; $display("[TB] FAIL t3_count: got %0d, want 15", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'h0001_0000 + 32'(i % 5)) begin
                errors++; $display("[TB] FAIL t3_word%0d: got %h, want %h", i, got[i], 32'h0001_0000 + 32'(i % 5));
            end
        end
        checks++; if (n_load !== 6)      begin errors++; $display("[TB] FAIL t3_load_cycles: got %0d, want 6", n_load); end
        checks++; if (n_done !== 1)      begin errors++; $display("[TB] FAIL t3_done_count: got %0d, want 1", n_done); end
        checks++; if (gaps.size() !== 2) begin errors++; $display("[TB] FAIL t3_gap_count: got %0d, want 2", gaps.size()); end
        for (int i = 0; i < gaps.size(); i++) begin
            checks++;
            if (gaps[i] !== 4) begin errors++; $display("[TB] FAIL t3_gap%0d: got %0d cycles, want 4", i, gaps[i]); end
        end
    endtask

    task automatic test_abort();
        int late_done;
        play(10'd16, 8'd0, 1'b0, 40, 300);
        checks++; if (got.size() !== 40) begin errors++; $display("[TB] FAIL t4_count: got %0d, want 40", got.size()); end
        checks++; if (got[39] !== 32'h0001_0007) begin errors++; $display("[TB] FAIL t4_word39: got %h, want 00010007", got[39]); end
        checks++; if (n_done !== 0)   begin errors++; $display("[TB] FAIL t4_done_before: got %0d, want 0", n_done); end
        checks++; if (dout_v !== 1'b0) begin errors++; $display("[TB] FAIL t4_dout_v: got %b, want 0", dout_v); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL t4_busy: got %b, want 0", busy); end
        checks++; if (load !== 1'b0)   begin errors++; $display("[TB] FAIL t4_load: got %b, want 0", load); end
        late_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) late_done++;
            tick();
        end
        checks++; if (late_done !== 0) begin errors++; $display("[TB] FAIL t4_done_after: got %0d pulses, want 0", late_done); end
        play(10'd16, 8'd1, 1'b0, 0, 100);
        checks++; if (got.size() !== 16) begin errors++; $display("[TB] FAIL t4_replay_count: got %0d, want 16", got.size()); end
        checks++; if (got[0] !== 32'h0001_0000) begin errors++; $display("[TB] FAIL t4_replay_word0: got %h, want 00010000", got[0]); end
    endtask

    task automatic test_write_rules();
        frame_len = 10'd16; num_frames = 8'd1; dout_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        checks++; if (wr_err !== 1'b1) begin errors++; $display("[TB] FAIL t5_wr_err_pulse: got %b, want 1", wr_err); end
        tick();
        checks++; if (wr_err !== 1'b0) begin errors++; $display("[TB] FAIL t5_wr_err_clear: got %b, want 0", wr_err); end
        for (int i = 0; i < 100 && busy; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t5_finish: busy %b, want 0", busy); end
        play(10'd16, 8'd1, 1'b0, 0, 100);
        checks++; if (got[5] !== 32'h0001_0005) begin errors++; $display("[TB] FAIL t5_dropped_write: got %h, want 00010005", got[5]); end
        // write and start share one IDLE cycle
        wr_en = 1'b1; wr_addr = 9'd0; wr_data = 32'h0BAD_0000;
        play(10'd4, 8'd1, 1'b0, 0, 100);
        checks++; if (got[0] !== 32'h0BAD_0000) begin errors++; $display("[TB] FAIL t5_write_start: got %h, want 0bad0000", got[0]); end
        checks++; if (got[1] !== 32'h0001_0001) begin errors++; $display("[TB] FAIL t5_write_start_w1: got %h, want 00010001", got[1]); end
        play(10'd0, 8'd1, 1'b0, 0, 20);
        checks++; if (n_done !== 1)  begin errors++; $display("[TB] FAIL t5_zero_done: got %0d, want 1", n_done); end
        checks++; if (n_load !== 0)  begin errors++; $display("[TB] FAIL t5_zero_load: got %0d, want 0", n_load); end
        checks++; if (n_valid !== 0) begin errors++; $display("[TB] FAIL t5_zero_valid: got %0d, want 0", n_valid); end
        checks++; if (end_cyc !== 2) begin errors++; $display("[TB] FAIL t5_zero_end: got %0d, want 2", end_cyc); end
    endtask

`ifdef PE_SRC_CHECKSUM_EN
    task automatic test_checksum();
        write_word(9'd0, 32'h1);
        write_word(9'd1, 32'h2);
        write_word(9'd2, 32'h4);
        write_word(9'd3, 32'h8);
        play(10'd4, 8'd1, 1'b0, 0, 100);
        checks++; if (checksum !== 32'hF) begin errors++; $display("[TB] FAIL t6_checksum: got %h, want 0000000f", checksum); end
        tick();
        tick();
        checks++; if (checksum !== 32'hF) begin errors++; $display("[TB] FAIL t6_checksum_hold: got %h, want 0000000f", checksum); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_multi_frame();
        test_abort();
        test_write_rules();
`ifdef PE_SRC_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
